switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
Input conditioning stage that sits directly upstream of the cpu3 `switches` port. It synchronises the asynchronous board switch word into the `clock` domain and debounces it as a whole word. It presents a stable registered `switches` value to the CPU, plus a change-notification handshake. This ensures the CPU never sees metastable or bouncing input values.

Parameters:
WORD_W, 8, width of switch word (matches cpu3 WORD_W)
DEBOUNCE_CYCLES, 16, consecutive stable clock cycles required before a new value is accepted; legal range 2..65535
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, rising-edge
n_reset  input  1  asynchronous active-low reset
raw_switches  input  WORD_W  unsynchronised board switch levels
switches  output  WORD_W  debounced, registered switch word to cpu3
sw_valid  output  1  high once the first debounced value has been accepted since reset
sw_change  output  1  single-cycle pulse on the cycle `switches` takes a new value
change_pending  output  1  sticky flag, set by sw_change, cleared by sw_ack
sw_ack  input  1  consumer acknowledge; clears change_pending

Behaviour:
- Reset (n_reset low, asynchronous):
  - sync1, sync2, candidate, switches <= 0.
  - count <= 0.
  - sw_valid, sw_change, change_pending <= 0.
  - Deassertion is sampled at the next rising clock edge; no output glitches during reset.
- Synchroniser: sync1 <= raw_switches; sync2 <= sync1. Only sync2 is used downstream.
- Debounce (every rising edge):
  - If sync2 != candidate: candidate <= sync2, count <= 0.
  - Else, if count < DEBOUNCE_CYCLES-1: count <= count+1.
  - Else (count == DEBOUNCE_CYCLES-1, saturated): the value is accepted. Count holds at saturation.
- Accept, in the cycle where count == DEBOUNCE_CYCLES-1 and sync2 == candidate:
  - If candidate != switches, or sw_valid == 0: switches <= candidate, sw_change <= 1.
  - Otherwise sw_change <= 0.
  - sw_valid <= 1, sticky until reset.
- sw_change is high for exactly one cycle per accepted change.
  - The first acceptance after reset pulses sw_change even when the value equals 0.
  - An unchanged word never re-pulses.
- Latency: raw_switches changes before edge 0 and stays stable. Then:
  - sync1 = new at edge 0, sync2 at edge 1, candidate at edge 2 (count 0).
  - switches and sw_change update at edge DEBOUNCE_CYCLES+2.
- Bounce: any sync2 difference from candidate restarts count at 0. Toggling faster than DEBOUNCE_CYCLES never alters switches.
- Return-to-old-value: if raw bounces away and settles back to the current switches value, acceptance produces no sw_change pulse (after sw_valid is set).
- change_pending:
  - Set on any cycle where sw_change is 1.
  - Cleared on a cycle with sw_ack == 1 and sw_change == 0.
  - If sw_ack and sw_change occur in the same cycle, set wins: pending stays 1.
  - sw_ack while pending is 0 has no effect.
- Reset mid-debounce: all state is cleared immediately. A partially counted value is discarded, and the full latency restarts after reset release.
- Widths: count is unsigned CNT_W and never wraps, because it saturates at DEBOUNCE_CYCLES-1.

Optional Feature:
Macro SWITCH_SYNC3_EN.
- Defined: a third synchroniser flop (sync3) is inserted, and sync3 feeds the debounce logic. Reset value is 0. Latency becomes DEBOUNCE_CYCLES+3 edges.
- Undefined: two-flop synchroniser exactly as in Behaviour. Latency is DEBOUNCE_CYCLES+2 edges.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset check. Hold n_reset low, with raw_switches=8'hA5 toggling. Required: switches=0, sw_valid=0, sw_change=0, change_pending=0 throughout reset. Pulse n_reset low for 2 ns mid-cycle: state clears asynchronously.
2. Clean change, DEBOUNCE_CYCLES=4. After reset, set raw_switches=8'b00001111 and hold. Required: switches=8'h0F and a single sw_change pulse at edge 6. sw_valid=1 from then on. change_pending=1 until sw_ack.
3. Bounce rejection, DEBOUNCE_CYCLES=4. From settled 8'h0F, toggle raw between 8'h09 and 8'h0F every 2 cycles for 40 cycles, then hold 8'h09. Required: switches stays 8'h0F during the bounce. It then becomes 8'h09 exactly 6 edges after the final transition, with one sw_change pulse.
4. Return-to-old. From settled 8'h09, pulse raw to 8'h19 for 2 cycles, then back to 8'h09. Required: switches stays 8'h09 and no sw_change pulse occurs.
5. Handshake collision. Arrange for sw_ack=1 on the same edge that sw_change=1 (value 8'h14). Required: change_pending stays 1. A subsequent sw_ack with no change clears it to 0.
6. SWITCH_SYNC3_EN build. Repeat scenario 2. Required: switches=8'h0F at edge 7, not edge 6.

Source files
------------

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises and debounces the asynchronous board
// switch word before it reaches the cpu3 `switches` port.
//
// Ports:
//   clock          system clock, rising edge
//   n_reset        asynchronous active-low reset
//   raw_switches   unsynchronised board switch levels
//   switches       debounced, registered switch word
//   sw_valid       set once the first debounced word is accepted (sticky)
//   sw_change      one-cycle pulse when `switches` takes a new value
//   change_pending sticky change flag, cleared by sw_ack
//   sw_ack         consumer acknowledge for change_pending
//
// Build option: define SWITCH_SYNC3_EN for a three-flop synchroniser
// (latency DEBOUNCE_CYCLES+3 instead of DEBOUNCE_CYCLES+2).
module switch_conditioner #(
  parameter int unsigned WORD_W          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] raw_switches,
  output logic [WORD_W-1:0] switches,
  output logic              sw_valid,
  output logic              sw_change,
  output logic              change_pending,
  input  logic              sw_ack
);

  // Count value at which the candidate is considered stable.
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WORD_W-1:0] sync1;
  logic [WORD_W-1:0] sync2;
  logic [WORD_W-1:0] sync_out;
  logic [WORD_W-1:0] candidate;
  logic [CNT_W-1:0]  count;

  logic [WORD_W-1:0] candidate_d;
  logic [CNT_W-1:0]  count_d;
  logic [WORD_W-1:0] switches_d;
  logic              valid_d;
  logic              change_d;
  logic              pending_d;
  logic              accept;

`ifdef SWITCH_SYNC3_EN
  logic [WORD_W-1:0] sync3;

  // Three-flop synchroniser into the clock domain.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw_switches;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign sync_out = sync3;
`else
  // Two-flop synchroniser into the clock domain.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_switches;
      sync2 <= sync1;
    end
  end

  assign sync_out = sync2;
`endif

  // Debounce, acceptance and change handshake next-state logic.
  always_comb begin
    candidate_d = candidate;
    count_d     = count;
    switches_d  = switches;
    valid_d     = sw_valid;
    change_d    = 1'b0;
    pending_d   = change_pending;
    accept      = 1'b0;

    if (sync_out != candidate) begin
      candidate_d = sync_out;
      count_d     = '0;
    end else if (count < CNT_SAT) begin
      count_d = count + CNT_W'(1);
    end else begin
      accept = 1'b1;
    end

    // First acceptance after reset always pulses, even for an all-zero word.
    if (accept) begin
      if ((candidate != switches) || !sw_valid) begin
        switches_d = candidate;
        change_d   = 1'b1;
      end
      valid_d = 1'b1;
    end

    // A change in the same cycle as an acknowledge keeps the flag set.
    if (sw_change) begin
      pending_d = 1'b1;
    end else if (sw_ack) begin
      pending_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      candidate      <= '0;
      count          <= '0;
      switches       <= '0;
      sw_valid       <= 1'b0;
      sw_change      <= 1'b0;
      change_pending <= 1'b0;
    end else begin
      candidate      <= candidate_d;
      count          <= count_d;
      switches       <= switches_d;
      sw_valid       <= valid_d;
      sw_change      <= change_d;
      change_pending <= pending_d;
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Testbench for switch_conditioner: directed scenarios followed by random
// switch activity, compared against a sample-window reference model. Every
// expected sw_change pulse is queued with its edge number and matched by an
// independent monitor.
module tb_switch_conditioner;

  localparam int unsigned WORD_W = 8;
  localparam int          DEB    = 4;
  localparam int unsigned CNT_W  = 3;
`ifdef SWITCH_SYNC3_EN
  localparam int          NSYNC  = 3;
`else
  localparam int          NSYNC  = 2;
`endif

  logic              clock = 1'b0;
  logic              n_reset = 1'b0;
  logic [WORD_W-1:0] raw_switches = '0;
  logic              sw_ack = 1'b0;
  logic [WORD_W-1:0] switches;
  logic              sw_valid;
  logic              sw_change;
  logic              change_pending;

  switch_conditioner #(
    .WORD_W          (WORD_W),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clock          (clock),
    .n_reset        (n_reset),
    .raw_switches   (raw_switches),
    .switches       (switches),
    .sw_valid       (sw_valid),
    .sw_change      (sw_change),
    .change_pending (change_pending),
    .sw_ack         (sw_ack)
  );

  initial forever #5 clock = ~clock;

  // Reference model: a word is accepted once the last DEB+1 values seen
  // after the synchroniser delay are all identical.
  typedef struct {
    logic [WORD_W-1:0] val;
    int                cyc;
  } exp_t;

  logic [WORD_W-1:0] pipe_q[$];
  logic [WORD_W-1:0] win_q[$];
  exp_t              sb_q[$];
  logic [WORD_W-1:0] m_sw;
  logic              m_valid;
  logic              m_chg;
  logic              m_pend;
  int                edge_cnt = 0;
  bit                mon_en = 1'b0;
  int                checks = 0;
  int                errors = 0;

  function automatic void model_reset();
    pipe_q.delete();
    for (int i = 0; i < NSYNC; i++) pipe_q.push_back('0);
    win_q.delete();
    win_q.push_back('0);
    sb_q.delete();
    m_sw    = '0;
    m_valid = 1'b0;
    m_chg   = 1'b0;
    m_pend  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [WORD_W-1:0] raw, input logic ack);
    logic [WORD_W-1:0] tap;
    bit                stable;
    m_pend = m_chg | (m_pend & ~ack);
    m_chg  = 1'b0;
    pipe_q.push_back(raw);
    tap = pipe_q.pop_front();
    win_q.push_back(tap);
    if (win_q.size() > DEB + 1) void'(win_q.pop_front());
    stable = (win_q.size() == DEB + 1);
    foreach (win_q[i]) if (win_q[i] != tap) stable = 1'b0;
    if (stable && ((tap != m_sw) || !m_valid)) begin
      m_sw  = tap;
      m_chg = 1'b1;
      sb_q.push_back('{tap, edge_cnt});
    end
    if (stable) m_valid = 1'b1;
  endfunction

  // Drive inputs just after the falling edge, then advance the model.
  task automatic step(input logic [WORD_W-1:0] raw, input logic ack, input logic rst);
    @(negedge clock);
    #1;
    if (!rst) model_reset();
    raw_switches = raw;
    sw_ack       = ack;
    n_reset      = rst;
    @(posedge clock);
    if (rst) begin
      edge_cnt++;
      model_edge(raw, ack);
    end
  endtask

  // 2 ns reset pulse in the high phase, between clock edges.
  task automatic async_pulse();
    #2;
    model_reset();
    n_reset = 1'b0;
    #2;
    n_reset = 1'b1;
  endtask

  function automatic void chk(input bit ok, input string name,
                              input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h edge=%0d t=%0t", name, act, exp, edge_cnt, $time);
    end
  endfunction

  // Monitor: per-cycle output checks plus scoreboard matching of pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or negedge n_reset);
      if (clock === 1'b1) begin
        #1;
        chk(switches === '0, "async_switches", switches, '0);
        chk(sw_valid === 1'b0, "async_valid", WORD_W'(sw_valid), '0);
        chk(sw_change === 1'b0, "async_change", WORD_W'(sw_change), '0);
        chk(change_pending === 1'b0, "async_pending", WORD_W'(change_pending), '0);
      end else if (mon_en) begin
        chk(switches === m_sw, "switches", switches, m_sw);
        chk(sw_valid === m_valid, "sw_valid", WORD_W'(sw_valid), WORD_W'(m_valid));
        chk(change_pending === m_pend, "change_pending",
            WORD_W'(change_pending), WORD_W'(m_pend));
        if (sw_change === 1'b1) begin
          chk(sb_q.size() > 0, "sb_unexpected_pulse", WORD_W'(sw_change), '0);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(switches === e.val, "sb_value", switches, e.val);
            chk(edge_cnt == e.cyc, "sb_edge", WORD_W'(edge_cnt), WORD_W'(e.cyc));
          end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
          chk(sw_change === 1'b1, "sb_missed_pulse", WORD_W'(sw_change), 8'h01);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [WORD_W-1:0] v;
    int                hold;
    model_reset();
    mon_en = 1'b1;

    // Reset held with the raw word toggling.
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 8'hA5 : 8'h5A, 1'b0, 1'b0);

    // Clean change to 0x0F, then acknowledge.
    for (int i = 0; i < 12; i++) step(8'h0F, 1'b0, 1'b1);
    step(8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h0F, 1'b0, 1'b1);

    // Reset pulse mid-debounce discards the partial count.
    for (int i = 0; i < 3; i++) step(8'h33, 1'b0, 1'b1);
    async_pulse();
    for (int i = 0; i < 12; i++) step(8'h0F, 1'b0, 1'b1);

    // Bounce between 0x09 and 0x0F, then settle on 0x09.
    for (int i = 0; i < 40; i++) step(((i / 2) % 2 == 0) ? 8'h09 : 8'h0F, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(8'h09, 1'b0, 1'b1);

    // Short excursion that returns to the current value.
    for (int i = 0; i < 2; i++) step(8'h19, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(8'h09, 1'b0, 1'b1);

    // Acknowledge coinciding with the change pulse, then a clean acknowledge.
    for (int i = 0; i < 12; i++) step(8'h14, m_chg, 1'b1);
    step(8'h14, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(8'h14, 1'b0, 1'b1);

    // Random switch activity with random acknowledges and occasional resets.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(4, 0))
        0:       v = 8'h00;
        1:       v = 8'hFF;
        2:       v = 8'h0F;
        3:       v = 8'hF0;
        default: v = WORD_W'($urandom);
      endcase
      hold = int'($urandom_range(9, 1));
      for (int k = 0; k < hold; k++) step(v, ($urandom_range(3, 0) == 0), 1'b1);
      if ($urandom_range(39, 0) == 0) async_pulse();
    end

    for (int i = 0; i < 12; i++) step(v, 1'b0, 1'b1);
    @(negedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
